// File: rtl/differentiator.sv
// Derivative term of a small PID loop: saturated first difference of the
// error sample, multiplied by K_d through repeated addition, then saturated
// back to a 6-bit signed contribution.
module differentiator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] e,
    input  logic       sample_valid,
    input  logic [5:0] K_d,
    output logic [5:0] d_contrib,
    output logic       d_valid,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nx;
    logic signed [5:0]  e_prev;
    logic signed [5:0]  diff;
    logic [5:0]         cnt;
    logic signed [11:0] acc;
    logic signed [6:0]  diff_raw;
    logic signed [5:0]  diff_sat;
    logic signed [5:0]  acc_sat;
    logic signed [11:0] diff_ext;

    // 7-bit difference cannot wrap; it is clipped to the 6-bit range
    // before it ever reaches the multiplier.
    assign diff_raw = $signed({e[5], e}) - $signed({e_prev[5], e_prev});
    assign diff_ext = $signed({{6{diff[5]}}, diff});
    assign busy     = (state != IDLE);

    // Saturate the raw difference and the final product to -32..31.
    always_comb begin
        diff_sat = diff_raw[5:0];
        if (diff_raw[6] != diff_raw[5])
            diff_sat = diff_raw[6] ? 6'sb100000 : 6'sb011111;
        acc_sat = acc[5:0];
        if (acc > 12'sd31)
            acc_sat = 6'sb011111;
        else if (acc < -12'sd32)
            acc_sat = 6'sb100000;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; nothing moves while ena is low.
    always_comb begin
        state_nx = state;
        if (ena) begin
            case (state)
                IDLE: if (sample_valid) state_nx = (K_d == 6'd0) ? DONE : MUL;
                MUL:  if (cnt == 6'd1)  state_nx = DONE;
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath: latch at accept, accumulate in MUL, publish in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_prev    <= '0;
            diff      <= '0;
            cnt       <= '0;
            acc       <= '0;
            d_contrib <= '0;
            d_valid   <= 1'b0;
        end else if (ena) begin
            d_valid <= (state == DONE);
            case (state)
                IDLE: if (sample_valid) begin
                    diff   <= diff_sat;
                    cnt    <= K_d;
                    e_prev <= e;
                    acc    <= '0;
                end
                MUL: begin
                    acc <= acc + diff_ext;
                    cnt <= cnt - 6'd1;
                end
                DONE: d_contrib <= acc_sat;
                default: ;
            endcase
        end else begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_differentiator.sv
// Directed bench for the differentiator: each vector is a sample/gain pair
// with a hand-computed contribution and latency.
module tb_differentiator;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic signed [5:0] e = '0;
    logic              sample_valid = 1'b0;
    logic [5:0]        K_d = '0;
    logic signed [5:0] d_contrib;
    logic              d_valid;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;

    differentiator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .e            (e),
        .sample_valid (sample_valid),
        .K_d          (K_d),
        .d_contrib    (d_contrib),
        .d_valid      (d_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Accept one sample, optionally glitch sample_valid/K_d during MUL and
    // stall ena, then check latency, busy and the published result.
    task automatic run(input int ev, input int kd, input int glitch,
                       input int stall, input int exp_d, input int exp_lat);
        int lat;
        @(negedge clk);
        e = 6'(ev); K_d = 6'(kd); sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        lat = 0;
        while (!d_valid && lat < 200) begin
            chk("busy", int'(busy), 1);
            if (glitch != 0 && lat == 1) begin
                sample_valid = 1'b1; e = 6'sd0; K_d = 6'd63;
            end
            if (lat == 2) sample_valid = 1'b0;
            if (stall > 0 && lat == 2) ena = 1'b0;
            if (stall > 0 && lat == 2 + stall) ena = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1;
        sample_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("d_contrib", int'(d_contrib), exp_d);
        chk("busy_at_valid", int'(busy), 0);
        @(posedge clk); #1;
        chk("d_valid_pulse", int'(d_valid), 0);
        chk("d_contrib_hold", int'(d_contrib), exp_d);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_contrib", int'(d_contrib), 0);
        chk("rst_d_valid", int'(d_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk) rst_n = 1'b1;

        run(5, 3, 0, 0, 15, 4);      // diff 5 against reset e_prev
        run(2, 4, 0, 0, -12, 5);     // diff -3
        run(2, 2, 0, 0, 0, 3);       // diff 0
        run(0, 0, 0, 0, 0, 1);       // K_d=0, e_prev -> 0
        run(-20, 5, 0, 0, -32, 6);   // -100 saturates
        run(-32, 0, 0, 0, 0, 1);     // e_prev -> -32
        run(31, 1, 0, 0, 31, 2);     // diff 63 clipped to 31
        run(21, 3, 1, 3, -30, 7);    // ignored pulse, K_d change, 3-cycle stall
        run(26, 2, 0, 0, 10, 3);     // e_prev must be 21, not 0

        // Reset in the middle of MUL.
        @(negedge clk);
        e = 6'sd10; K_d = 6'd5; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_contrib", int'(d_contrib), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_d_valid", int'(d_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (d_valid) seen = 1;
        end
        chk("no_valid_after_abort", seen, 0);
        run(7, 1, 0, 0, 7, 2);       // differenced against 0

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/differentiator.md
DIFFERENTIATOR -- requirements
Module: differentiator

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  global enable; low freezes all state.
REQ-005 e  input  6  error sample, two's-complement signed (-32..31).
REQ-006 sample_valid  input  1  e is valid this cycle; request to start a computation.
REQ-007 K_d  input  6  derivative gain, unsigned (0..63); sampled at accept.
REQ-008 d_contrib  output  6  derivative contribution, signed, registered.
REQ-009 d_valid  output  1  one-cycle pulse; d_contrib updated this cycle.
REQ-010 busy  output  1  high while a computation is in progress (state not IDLE).

Function
REQ-011 The block SHALL implement an FSM with states IDLE, MUL, DONE.
REQ-012 Accept: in IDLE with ena=1 and sample_valid=1, the block SHALL compute diff = e - e_prev at 7-bit width, saturate it to -32..31, latch the diff, latch K_d into a down-counter, set e_prev <= e, clear the accumulator, and go to MUL (or to DONE if K_d=0).
REQ-013 MUL: each cycle with ena=1, the block SHALL add the sign-extended diff to a 12-bit signed accumulator and decrement the counter; when the counter reaches 1 before decrement, it SHALL go to DONE.
REQ-014 The accumulator SHALL NOT overflow: 12-bit signed covers -32*63 = -2016 through 31*63 = 1953.
REQ-015 DONE: the block SHALL load d_contrib with the accumulator saturated to -32..31, assert d_valid for exactly that cycle, and return to IDLE.
REQ-016 Latency SHALL be K_d+1 cycles from the accept edge to the d_valid edge; K_d=0 gives latency 1 and d_contrib=0.
REQ-017 sample_valid while busy=1 SHALL be ignored: no accept, and e_prev unchanged.
REQ-018 sample_valid in the DONE cycle SHALL be ignored; a new accept is possible only from IDLE.
REQ-019 ena=0 SHALL hold state, counter, accumulator, e_prev, and d_contrib unchanged, hold d_valid low, and block accepts; operation resumes where it stopped when ena returns to 1.
REQ-020 K_d changes after accept SHALL NOT affect the computation in progress.
REQ-021 d_contrib SHALL hold its last value between d_valid pulses.
REQ-022 Diff saturation SHALL apply before multiplication: e=31, e_prev=-32 gives diff=31, not 63.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, e_prev=0, accumulator=0, counter=0, diff=0, d_contrib=0, d_valid=0, busy=0.
REQ-024 Reset asserted mid-computation SHALL abort it with no d_valid pulse.
REQ-025 The first sample after reset SHALL be differenced against e_prev=0.

Verification
REQ-026 Reset, then e=5, K_d=3, one sample_valid -> busy for 4 cycles, then d_valid with d_contrib=15 on the 4th edge after accept.
REQ-027 Second sample e=2, K_d=4 -> diff=-3, d_contrib=-12; third sample e=2 -> d_contrib=0.
REQ-028 From e_prev=0: e=-20 with K_d=5 -> product -100, d_contrib saturates to -32; from e_prev=-32: e=31 with K_d=1 -> diff saturates to 31, d_contrib=31.
REQ-029 K_d=0 with any e -> d_valid one cycle after accept, d_contrib=0, and e_prev still updated.
REQ-030 sample_valid pulsed during MUL with a different e -> ignored; the following diff uses the e from the accepted sample; ena dropped for 3 cycles mid-MUL -> latency increases by exactly 3 and the result is unchanged.
REQ-031 rst_n pulsed low during MUL -> all outputs 0 immediately, no d_valid, and the next sample is differenced against 0.
